// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, inserts bubbles on flush/load-use,
// and selects EX operands. Optional macro FORWARD_EN adds EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_ALUCtl,
    input  logic              id_Sign,
    input  logic [2:0]        id_BranchType,
    input  logic              id_ALUSrc1,
    input  logic              id_ALUSrc2,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_wr_reg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              mem_RegWrite,
    input  logic [4:0]        mem_wr_reg,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_wr_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [4:0]        ex_ALUCtl,
    output logic              ex_Sign,
    output logic [2:0]        ex_BranchType,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [4:0]        ex_wr_reg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_valid,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        alu_ctl;
        logic              sign;
        logic [2:0]        branch_type;
        logic              alu_src1;
        logic              alu_src2;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        wr_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_regs_t;

    ex_regs_t          ex_q;
    ex_regs_t          ex_d;
    logic              producer;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Register 0 is hard-wired, so a write to it never matches.
    function automatic logic reg_hit(input logic we, input logic [4:0] wr, input logic [4:0] idx);
        return we && (wr != 5'd0) && (wr == idx);
    endfunction

    function automatic ex_regs_t bubble();
        ex_regs_t b;
        b             = '0;
        b.alu_ctl     = 5'b11111;
        b.branch_type = 3'b111;
        return b;
    endfunction

`ifdef FORWARD_EN
    assign producer = ex_q.mem_read;

    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (reg_hit(mem_RegWrite, mem_wr_reg, ex_q.rs))
            fwd_rs = mem_result;
        else if (reg_hit(wb_RegWrite, wb_wr_reg, ex_q.rs))
            fwd_rs = wb_data;
        if (reg_hit(mem_RegWrite, mem_wr_reg, ex_q.rt))
            fwd_rt = mem_result;
        else if (reg_hit(wb_RegWrite, wb_wr_reg, ex_q.rt))
            fwd_rt = wb_data;
    end
`else
    // Without forwarding, any in-flight writer must drain before a dependent issues.
    logic unused_fwd;

    assign producer   = ex_q.mem_read | ex_q.reg_write;
    assign fwd_rs     = ex_q.rs_data;
    assign fwd_rt     = ex_q.rt_data;
    assign unused_fwd = ^{mem_RegWrite, mem_wr_reg, mem_result, ex_q.rs, ex_q.rt};
`endif

    assign load_use_stall = ex_q.valid && producer && id_valid &&
                            (reg_hit(1'b1, ex_q.wr_reg, id_rs) || reg_hit(1'b1, ex_q.wr_reg, id_rt));

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = bubble();
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = bubble();
        end else begin
            ex_d.valid       = id_valid;
            ex_d.alu_ctl     = id_ALUCtl;
            ex_d.sign        = id_Sign;
            ex_d.branch_type = id_BranchType;
            ex_d.alu_src1    = id_ALUSrc1;
            ex_d.alu_src2    = id_ALUSrc2;
            ex_d.rs_data     = reg_hit(wb_RegWrite, wb_wr_reg, id_rs) ? wb_data : id_rs_data;
            ex_d.rt_data     = reg_hit(wb_RegWrite, wb_wr_reg, id_rt) ? wb_data : id_rt_data;
            ex_d.imm         = id_imm;
            ex_d.shamt       = id_shamt;
            ex_d.rs          = id_rs;
            ex_d.rt          = id_rt;
            ex_d.wr_reg      = id_wr_reg;
            ex_d.reg_write   = id_RegWrite;
            ex_d.mem_read    = id_MemRead;
            ex_d.mem_write   = id_MemWrite;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex_q <= bubble();
        else
            ex_q <= ex_d;
    end

    assign ex_in1        = ex_q.alu_src1 ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign ex_in2        = ex_q.alu_src2 ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_ALUCtl     = ex_q.alu_ctl;
    assign ex_Sign       = ex_q.sign;
    assign ex_BranchType = ex_q.branch_type;
    assign ex_wr_reg     = ex_q.wr_reg;
    assign ex_RegWrite   = ex_q.reg_write;
    assign ex_MemRead    = ex_q.mem_read;
    assign ex_MemWrite   = ex_q.mem_write;
    assign ex_valid      = ex_q.valid;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL use clk, input, 1, rising-edge clock for all state.
REQ-002 The module SHALL use reset, input, 1, asynchronous active-high reset.
REQ-003 The module SHALL accept stall, input, 1, hold all ID/EX state when high.
REQ-004 The module SHALL accept flush, input, 1, load a bubble on the next edge when high.
REQ-005 The module SHALL accept ID fields: id_valid 1; id_ALUCtl 5; id_Sign 1; id_BranchType 3; id_ALUSrc1 1 (shamt select); id_ALUSrc2 1 (imm select); id_rs_data 32; id_rt_data 32; id_imm 32; id_shamt 5; id_rs 5; id_rt 5; id_wr_reg 5; id_RegWrite 1; id_MemRead 1; id_MemWrite 1.
REQ-006 The module SHALL accept forwarding sources: mem_RegWrite 1, mem_wr_reg 5, mem_result 32, wb_RegWrite 1, wb_wr_reg 5, wb_data 32.
REQ-007 The module SHALL drive ALU-facing outputs: ex_in1 32, ex_in2 32, ex_ALUCtl 5, ex_Sign 1, ex_BranchType 3.
REQ-008 The module SHALL drive ex_store_data 32, ex_wr_reg 5, ex_RegWrite 1, ex_MemRead 1, ex_MemWrite 1, ex_valid 1.
REQ-009 The module SHALL drive load_use_stall, output, 1, combinational request for upstream to hold IF/ID.

Function
REQ-010 The module SHALL capture all id_* fields on a rising clk edge when no higher-priority action applies; latency ID to EX is exactly one cycle.
REQ-011 Edge priority SHALL be: reset > flush > stall (hold) > load_use_stall (bubble) > normal capture.
REQ-012 A bubble SHALL set ex_valid=0, RegWrite=MemRead=MemWrite=0, ALUCtl=5'b11111, BranchType=3'b111, wr_reg=0, and data registers to 0.
REQ-013 load_use_stall SHALL be 1 iff ex_valid & ex_MemRead & ex_wr_reg!=0 & id_valid & (ex_wr_reg==id_rs | ex_wr_reg==id_rt).
REQ-014 At capture, if wb_RegWrite & wb_wr_reg!=0 & wb_wr_reg==id_rs (resp. id_rt), wb_data SHALL be captured instead of id_rs_data (resp. id_rt_data).
REQ-015 Forwarded rs value SHALL be mem_result if mem_RegWrite & mem_wr_reg!=0 & mem_wr_reg==ex_rs; else wb_data if the same test holds for wb; else the registered rs data; rt likewise.
REQ-016 ex_in1 SHALL equal {27'b0, registered shamt} when registered ALUSrc1=1, else the forwarded rs value.
REQ-017 ex_in2 SHALL equal the registered imm when registered ALUSrc2=1, else the forwarded rt value.
REQ-018 ex_store_data SHALL always equal the forwarded rt value, independent of ALUSrc2.
REQ-019 Register 0 SHALL never be a forwarding or bypass match.
REQ-020 With stall held high, outputs SHALL remain constant except combinational forwarding changes from mem_*/wb_*.
REQ-021 flush and load_use_stall in the same cycle SHALL produce exactly one bubble.

Reset
REQ-022 Asserting reset SHALL immediately force the bubble state of REQ-012 regardless of clk, including mid-stall.
REQ-023 After reset deassertion the first rising edge SHALL perform a normal capture if flush, stall and load_use_stall are low.

Configuration
REQ-024 With FORWARD_EN defined, REQ-015 forwarding SHALL be implemented.
REQ-025 Without FORWARD_EN, forwarded values SHALL equal the registered rs/rt data; load_use_stall SHALL additionally assert for any valid ex_RegWrite producer matching id_rs/id_rt (non-zero), forcing bubbles until the hazard clears; REQ-014 bypass remains.

Verification
REQ-026 Reset mid-stall: stall=1, reset pulse -> ex_valid=0, ex_ALUCtl=5'b11111, ex_BranchType=3'b111 immediately.
REQ-027 EX/MEM forward: ex_rs=5, mem_RegWrite=1, mem_wr_reg=5, mem_result=0x1234, wb_wr_reg=5, wb_data=0x9999 -> ex_in1=0x00001234.
REQ-028 Load-use: ex_MemRead=1, ex_wr_reg=8, id_rt=8, id_valid=1 -> load_use_stall=1; next edge ex_valid=0; following edge captures the ID instruction.
REQ-029 Shift immediate: id_ALUSrc1=1, id_shamt=3, id_ALUSrc2=0, id_rt_data=0x10 -> ex_in1=0x3, ex_in2=0x10.
REQ-030 Priority: flush=1 and stall=1 same edge -> bubble; id_rs=0 with mem_wr_reg=0, mem_RegWrite=1 -> no forward, ex_in1=registered rs data.
